// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC bus read sequencer.
//   state_e       : sequencer state encoding
//   bus_ctrl_t    : registered bus-side outputs (strobes, direction, address byte)
//   phase_cnt_w() : width of the per-phase down-counter for a given T_PHASE
//   bus_for_state : bus output pattern for a state and address
package rtc_bus_pkg;

  localparam logic [7:0] RTC_ADDR1 = 8'h21;  // seconds
  localparam logic [7:0] RTC_ADDR2 = 8'h22;  // minutes
  localparam logic [7:0] RTC_ADDR3 = 8'h23;  // hours

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_SETUP,
    ST_ADDR_WR,
    ST_ADDR_HOLD,
    ST_DATA_RD,
    ST_DATA_HOLD,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       a_d;
    logic       ad_oe;
    logic [7:0] ad_out;
  } bus_ctrl_t;

  localparam bus_ctrl_t BUS_IDLE = '{
    cs_n:   1'b1,
    rd_n:   1'b1,
    wr_n:   1'b1,
    a_d:    1'b1,
    ad_oe:  1'b0,
    ad_out: 8'h00
  };

  function automatic int unsigned phase_cnt_w(input int unsigned t_phase);
    return $clog2(t_phase + 1);
  endfunction

  // Bus pattern while sitting in a given state; address is driven only in the address states.
  function automatic bus_ctrl_t bus_for_state(input state_e st, input logic [7:0] addr);
    bus_ctrl_t b;
    b = BUS_IDLE;
    case (st)
      ST_ADDR_SETUP, ST_ADDR_HOLD: begin
        b.cs_n   = 1'b0;
        b.ad_oe  = 1'b1;
        b.ad_out = addr;
      end
      ST_ADDR_WR: begin
        b.cs_n   = 1'b0;
        b.wr_n   = 1'b0;
        b.ad_oe  = 1'b1;
        b.ad_out = addr;
      end
      ST_DATA_RD: begin
        b.cs_n = 1'b0;
        b.a_d  = 1'b0;
        b.rd_n = 1'b0;
      end
      ST_DATA_HOLD: begin
        b.cs_n = 1'b0;
        b.a_d  = 1'b0;
      end
      default: b = BUS_IDLE;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/rtc_bus_reader_phase_timer.sv
// Loadable down-counter that times one bus phase.
//   clk, rst_n : clock, async active-low reset
//   load       : reload the counter with load_val this cycle
//   load_val   : reload value (phase length minus one)
//   tc_c       : combinational terminal count, high while the counter is zero
module phase_timer #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc_c
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Reload has priority; otherwise count down and rest at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_c = (cnt_q == '0);

endmodule

// File: rtl/rtc_bus_reader.sv
// Bus-master sequencer that reads three RTC registers over the multiplexed
// 8-bit address/data bus and latches the returned bytes.
//   clk, rst_n         : clock, async active-low reset
//   start              : request a three-register read (sampled in IDLE only)
//   ad_in              : bus value from the pad
//   ad_out, ad_oe      : address byte and pad output enable
//   cs_n, rd_n, wr_n   : RTC chip select and strobes (active low)
//   a_d                : 1 = address phase, 0 = data phase
//   rg1, rg2, rg3      : latched bytes from ADDR1..ADDR3
//   busy, done         : sequence in progress / one-cycle completion pulse
//   sel_vga            : 0 while busy (VGA shows live bus), 1 otherwise
module rtc_bus_reader
  import rtc_bus_pkg::*;
#(
  parameter int unsigned T_PHASE = 4,
  parameter logic [7:0]  ADDR1   = RTC_ADDR1,
  parameter logic [7:0]  ADDR2   = RTC_ADDR2,
  parameter logic [7:0]  ADDR3   = RTC_ADDR3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       a_d,
  output logic [7:0] rg1,
  output logic [7:0] rg2,
  output logic [7:0] rg3,
  output logic       busy,
  output logic       done,
  output logic       sel_vga
);

  localparam int unsigned      CNT_W      = phase_cnt_w(T_PHASE);
  localparam logic [CNT_W-1:0] PHASE_LOAD = CNT_W'(T_PHASE - 1);
  localparam logic [1:0]       LAST_IDX   = 2'd2;

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  bus_ctrl_t  bus_q, bus_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       sel_vga_q, sel_vga_d;
  logic [7:0] rg1_q, rg1_d;
  logic [7:0] rg2_q, rg2_d;
  logic [7:0] rg3_q, rg3_d;
  logic [7:0] addr_c;
  logic       load_c;
  logic       tc_c;

  phase_timer #(
    .W(CNT_W)
  ) u_phase_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_c),
    .load_val (PHASE_LOAD),
    .tc_c     (tc_c)
  );

  // Next state and register index; the timer is reloaded on every entry into a bus state.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ADDR_SETUP;
          load_c  = 1'b1;
        end
      end
      ST_ADDR_SETUP: begin
        if (tc_c) begin
          state_d = ST_ADDR_WR;
          load_c  = 1'b1;
        end
      end
      ST_ADDR_WR: begin
        if (tc_c) begin
          state_d = ST_ADDR_HOLD;
          load_c  = 1'b1;
        end
      end
      ST_ADDR_HOLD: begin
        if (tc_c) begin
          state_d = ST_DATA_RD;
          load_c  = 1'b1;
        end
      end
      ST_DATA_RD: begin
        if (tc_c) begin
          state_d = ST_DATA_HOLD;
          load_c  = 1'b1;
        end
      end
      ST_DATA_HOLD: begin
        if (tc_c) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = ST_ADDR_SETUP;
            load_c  = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        idx_d   = 2'd0;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = 2'd0;
      end
    endcase
  end

  // Address for the register about to be accessed.
  always_comb begin
    case (idx_d)
      2'd0:    addr_c = ADDR1;
      2'd1:    addr_c = ADDR2;
      default: addr_c = ADDR3;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_comb begin
    bus_d     = bus_for_state(state_d, addr_c);
    busy_d    = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d    = (state_d == ST_DONE);
    sel_vga_d = ~busy_d;
  end

  // Capture the bus on the edge that ends the last DATA_RD cycle.
  always_comb begin
    rg1_d = rg1_q;
    rg2_d = rg2_q;
    rg3_d = rg3_q;
    if ((state_q == ST_DATA_RD) && tc_c) begin
      case (idx_q)
        2'd0:    rg1_d = ad_in;
        2'd1:    rg2_d = ad_in;
        default: rg3_d = ad_in;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= 2'd0;
      bus_q     <= BUS_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sel_vga_q <= 1'b1;
      rg1_q     <= 8'h00;
      rg2_q     <= 8'h00;
      rg3_q     <= 8'h00;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      bus_q     <= bus_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sel_vga_q <= sel_vga_d;
      rg1_q     <= rg1_d;
      rg2_q     <= rg2_d;
      rg3_q     <= rg3_d;
    end
  end

  assign ad_out  = bus_q.ad_out;
  assign ad_oe   = bus_q.ad_oe;
  assign cs_n    = bus_q.cs_n;
  assign rd_n    = bus_q.rd_n;
  assign wr_n    = bus_q.wr_n;
  assign a_d     = bus_q.a_d;
  assign rg1     = rg1_q;
  assign rg2     = rg2_q;
  assign rg3     = rg3_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign sel_vga = sel_vga_q;

endmodule

// File: tb/tb_rtc_bus_reader.sv
// Self-checking bench for rtc_bus_reader: a T_PHASE=4 instance for the
// main scenarios and a T_PHASE=1 instance for back-to-back operation.
// A behavioural RTC (byte memory addressed by the last written address)
// answers reads; other cycles put random noise on ad_in.
module tb_rtc_bus_reader;

  localparam int TP = 4;
  localparam int SEQ = 15 * TP;
  localparam int SEQ1 = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // T_PHASE = 4 instance
  logic       rst_n, start;
  logic [7:0] ad_in;
  logic [7:0] ad_out, rg1, rg2, rg3;
  logic       ad_oe, cs_n, rd_n, wr_n, a_d, busy, done, sel_vga;

  // T_PHASE = 1 instance
  logic       rst1_n, start1;
  logic [7:0] ad_in1;
  logic [7:0] ad_out1, rg1_1, rg2_1, rg3_1;
  logic       ad_oe1, cs_n1, rd_n1, wr_n1, a_d1, busy1, done1, sel_vga1;

  rtc_bus_reader #(.T_PHASE(TP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ad_in(ad_in),
    .ad_out(ad_out), .ad_oe(ad_oe), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
    .a_d(a_d), .rg1(rg1), .rg2(rg2), .rg3(rg3),
    .busy(busy), .done(done), .sel_vga(sel_vga)
  );

  rtc_bus_reader #(.T_PHASE(1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .start(start1), .ad_in(ad_in1),
    .ad_out(ad_out1), .ad_oe(ad_oe1), .cs_n(cs_n1), .rd_n(rd_n1), .wr_n(wr_n1),
    .a_d(a_d1), .rg1(rg1_1), .rg2(rg2_1), .rg3(rg3_1),
    .busy(busy1), .done(done1), .sel_vga(sel_vga1)
  );

  int checks = 0;
  int passed = 0;

  logic [7:0] mem [256];

  // Bus observers and RTC model, instance 0
  logic [7:0] laddr = 8'h00;
  logic [7:0] wr_log [$];
  int         rd_windows = 0, wr_bad = 0, rd_bad = 0, proto_viol = 0, sel_bad = 0;
  logic       wr_prev = 1'b1, rd_prev = 1'b1;

  always @(negedge clk) begin
    if (!rd_n && !wr_n) proto_viol++;
    if (ad_oe && !rd_n) proto_viol++;
    if (sel_vga !== !busy) sel_bad++;
    if (!wr_n && wr_prev) begin
      wr_log.push_back(ad_out);
      if (!(ad_oe && a_d)) wr_bad++;
    end
    if (!wr_n && a_d) laddr = ad_out;
    if (!rd_n && rd_prev) rd_windows++;
    if (!rd_n && (ad_oe || a_d)) rd_bad++;
    wr_prev = wr_n;
    rd_prev = rd_n;
    ad_in = !rd_n ? mem[laddr] : 8'($urandom);
  end

  // Bus observers and RTC model, instance 1
  logic [7:0] laddr1 = 8'h00;
  logic [7:0] wr_log1 [$];
  int         proto_viol1 = 0, sel_bad1 = 0;
  logic       wr_prev1 = 1'b1;

  always @(negedge clk) begin
    if (!rd_n1 && !wr_n1) proto_viol1++;
    if (ad_oe1 && !rd_n1) proto_viol1++;
    if (sel_vga1 !== !busy1) sel_bad1++;
    if (!wr_n1 && wr_prev1) wr_log1.push_back(ad_out1);
    if (!wr_n1 && a_d1) laddr1 = ad_out1;
    wr_prev1 = wr_n1;
    ad_in1 = !rd_n1 ? mem[laddr1] : 8'($urandom);
  end

  // Pulse start on instance 0 and compare busy/done against the expected timeline:
  // busy on sample n=1..SEQ, done only at n=SEQ+1, then idle.
  task automatic drive_sequence(input int inject_at, output int busy_err,
                                output int done_err, output int done_cnt);
    busy_err = 0;
    done_err = 0;
    done_cnt = 0;
    wr_log.delete();
    rd_windows = 0;
    @(negedge clk);
    start = 1'b1;
    for (int n = 1; n <= SEQ + 12; n++) begin
      @(negedge clk);
      start = (n == inject_at);
      if (busy !== (n <= SEQ)) busy_err++;
      if (done !== (n == SEQ + 1)) done_err++;
      if (done === 1'b1) done_cnt++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst1_n = 1'b0; start = 1'b0; start1 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({cs_n, rd_n, wr_n, a_d, ad_oe, busy, done, sel_vga} !== 8'b1111_0001) begin
      $display("FAIL reset_ctrl: got %b want 11110001",
               {cs_n, rd_n, wr_n, a_d, ad_oe, busy, done, sel_vga});
    end else passed++;
    checks++;
    if ({ad_out, rg1, rg2, rg3} !== 32'h0) begin
      $display("FAIL reset_data: got %h want 00000000", {ad_out, rg1, rg2, rg3});
    end else passed++;
    checks++;
    if ({cs_n1, rd_n1, wr_n1, ad_oe1, busy1, sel_vga1} !== 6'b111001) begin
      $display("FAIL reset_ctrl1: got %b want 111001",
               {cs_n1, rd_n1, wr_n1, ad_oe1, busy1, sel_vga1});
    end else passed++;
    rst_n = 1'b1; rst1_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({busy, cs_n, done} !== 3'b010) begin
      $display("FAIL idle_after_reset: busy/cs_n/done got %b want 010", {busy, cs_n, done});
    end else passed++;
  endtask

  task automatic test_single_read();
    int be, de, dc;
    mem[8'h21] = 8'h45; mem[8'h22] = 8'h30; mem[8'h23] = 8'h12;
    drive_sequence(0, be, de, dc);
    checks++;
    if (be !== 0) $display("FAIL single_busy_window: %0d wrong cycles, want 0", be);
    else passed++;
    checks++;
    if (de !== 0 || dc !== 1) $display("FAIL single_done_at_61: errs %0d pulses %0d, want 0/1", de, dc);
    else passed++;
    checks++;
    if ({rg1, rg2, rg3} !== 24'h453012) $display("FAIL single_rg: got %h want 453012", {rg1, rg2, rg3});
    else passed++;
    checks++;
    if (wr_log.size() != 3) begin
      $display("FAIL single_wr_addrs: got %0d write windows want 3", wr_log.size());
    end else if ({wr_log[0], wr_log[1], wr_log[2]} !== 24'h212223) begin
      $display("FAIL single_wr_addrs: got %h want 212223", {wr_log[0], wr_log[1], wr_log[2]});
    end else passed++;
    checks++;
    if (wr_bad !== 0 || rd_bad !== 0 || rd_windows !== 3) begin
      $display("FAIL single_bus_phases: wr_bad %0d rd_bad %0d rd_windows %0d, want 0 0 3",
               wr_bad, rd_bad, rd_windows);
    end else passed++;
  endtask

  task automatic test_random_reads();
    int be, de, dc;
    logic [23:0] exp;
    for (int it = 0; it < 4; it++) begin
      for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
      exp = {mem[8'h21], mem[8'h22], mem[8'h23]};
      drive_sequence(0, be, de, dc);
      checks++;
      if ({rg1, rg2, rg3} !== exp) $display("FAIL random_rg[%0d]: got %h want %h", it, {rg1, rg2, rg3}, exp);
      else passed++;
      checks++;
      if (be !== 0 || de !== 0 || dc !== 1) begin
        $display("FAIL random_timing[%0d]: busy_err %0d done_err %0d pulses %0d, want 0 0 1",
                 it, be, de, dc);
      end else passed++;
    end
  endtask

  task automatic test_start_ignored();
    int be, de, dc;
    for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
    drive_sequence(20, be, de, dc);
    checks++;
    if (dc !== 1 || de !== 0) $display("FAIL ignored_start_done: pulses %0d errs %0d, want 1/0", dc, de);
    else passed++;
    checks++;
    if (be !== 0 || rd_windows !== 3) begin
      $display("FAIL ignored_start_phases: busy_err %0d rd_windows %0d, want 0/3", be, rd_windows);
    end else passed++;
  endtask

  task automatic test_reset_mid_read();
    int   falls = 0;
    logic prev = 1'b1;
    int   stray = 0;
    int   be, de, dc;
    for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
    mem[8'h21] = 8'($urandom_range(1, 255));
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 200 && falls < 2; n++) begin
      @(negedge clk);
      if (!rd_n && prev) falls++;
      prev = rd_n;
    end
    checks++;
    if (falls != 2) $display("FAIL midreset_reach_rd2: saw %0d read windows want 2", falls);
    else passed++;
    checks++;
    if (rg1 !== mem[8'h21]) $display("FAIL midreset_rg1_before: got %h want %h", rg1, mem[8'h21]);
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({cs_n, rd_n, wr_n, ad_oe, busy, sel_vga} !== 6'b111001) begin
      $display("FAIL midreset_ctrl: got %b want 111001", {cs_n, rd_n, wr_n, ad_oe, busy, sel_vga});
    end else passed++;
    checks++;
    if ({rg1, rg2, rg3} !== 24'h0) $display("FAIL midreset_rg: got %h want 000000", {rg1, rg2, rg3});
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (busy !== 1'b0 || cs_n !== 1'b1) stray++;
    end
    checks++;
    if (stray !== 0) $display("FAIL midreset_stays_idle: %0d active cycles want 0", stray);
    else passed++;
    drive_sequence(0, be, de, dc);
    checks++;
    if ({rg1, rg2, rg3} !== {mem[8'h21], mem[8'h22], mem[8'h23]} || dc !== 1) begin
      $display("FAIL midreset_recover: rg %h pulses %0d want %h/1", {rg1, rg2, rg3}, dc,
               {mem[8'h21], mem[8'h22], mem[8'h23]});
    end else passed++;
  endtask

  task automatic test_back_to_back();
    int rises [$];
    int busy_cnt = 0, done_cnt = 0, bad_gap = 0;
    logic prev = 1'b0;
    for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
    wr_log1.delete();
    @(negedge clk);
    start1 = 1'b1;
    for (int n = 1; n <= 4 * (SEQ1 + 2); n++) begin
      @(negedge clk);
      if (busy1 && !prev) rises.push_back(n);
      prev = busy1;
      if (busy1 === 1'b1) busy_cnt++;
      if (done1 === 1'b1) done_cnt++;
    end
    start1 = 1'b0;
    checks++;
    if (rises.size() != 4 || rises[0] != 1) begin
      $display("FAIL b2b_starts: got %0d sequences want 4 starting at sample 1", rises.size());
    end else begin
      for (int i = 1; i < 4; i++) if (rises[i] - rises[i-1] != SEQ1 + 2) bad_gap++;
      if (bad_gap != 0) $display("FAIL b2b_starts: %0d gaps differ from %0d", bad_gap, SEQ1 + 2);
      else passed++;
    end
    checks++;
    if (busy_cnt !== 4 * SEQ1 || done_cnt !== 4) begin
      $display("FAIL b2b_counts: busy %0d done %0d want %0d/4", busy_cnt, done_cnt, 4 * SEQ1);
    end else passed++;
    checks++;
    if ({rg1_1, rg2_1, rg3_1} !== {mem[8'h21], mem[8'h22], mem[8'h23]}) begin
      $display("FAIL b2b_rg: got %h want %h", {rg1_1, rg2_1, rg3_1},
               {mem[8'h21], mem[8'h22], mem[8'h23]});
    end else passed++;
    checks++;
    if (wr_log1.size() < 3) begin
      $display("FAIL b2b_wr_addrs: got %0d write windows want >= 3", wr_log1.size());
    end else if ({wr_log1[0], wr_log1[1], wr_log1[2]} !== 24'h212223) begin
      $display("FAIL b2b_wr_addrs: got %h want 212223", {wr_log1[0], wr_log1[1], wr_log1[2]});
    end else passed++;
  endtask

  task automatic test_protocol();
    checks++;
    if (proto_viol !== 0 || proto_viol1 !== 0) begin
      $display("FAIL protocol: violations %0d/%0d want 0/0", proto_viol, proto_viol1);
    end else passed++;
    checks++;
    if (sel_bad !== 0 || sel_bad1 !== 0) begin
      $display("FAIL sel_vga_vs_busy: mismatches %0d/%0d want 0/0", sel_bad, sel_bad1);
    end else passed++;
  endtask

  initial begin
    rst_n = 1'b0; rst1_n = 1'b0; start = 1'b0; start1 = 1'b0;
    ad_in = 8'h00; ad_in1 = 8'h00;
    for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
    test_reset();
    test_single_read();
    test_random_reads();
    test_start_ignored();
    test_reset_mid_read();
    test_back_to_back();
    test_protocol();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
